// File: rtl/trigger_generator_pkg.sv
// Shared definitions for the trigger pulse-train generator: FSM states and default widths.
package trigger_generator_pkg;

  localparam int unsigned DEF_WIDTH_W  = 10;
  localparam int unsigned DEF_PERIOD_W = 24;
  localparam int unsigned DEF_COUNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } trig_state_t;

endpackage

// File: rtl/trigger_phase_counter.sv
// Loadable down-counter; terminal is high during the last cycle of a loaded phase.
module trigger_phase_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         terminal
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign terminal = (count == W'(1));

endmodule

// File: rtl/trigger_generator.sv
// Programmable trigger pulse-train generator (width, period, count) with differential output.
// Define TRIG_GEN_OBUFDS_EN to drive trigger_out_p/_n through an OBUFDS LVDS buffer.
module trigger_generator
  import trigger_generator_pkg::*;
#(
  parameter int unsigned WIDTH_W  = DEF_WIDTH_W,
  parameter int unsigned PERIOD_W = DEF_PERIOD_W,
  parameter int unsigned COUNT_W  = DEF_COUNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                enable_trigger,
  input  logic [WIDTH_W-1:0]  trigger_width,
  input  logic [PERIOD_W-1:0] trigger_period,
  input  logic [COUNT_W-1:0]  trigger_number,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  pulse_count,
  output logic                trigger_out,
  output logic                trigger_out_p,
  output logic                trigger_out_n
);

  trig_state_t         state;
  logic [WIDTH_W-1:0]  w_in, w_lat;
  logic [PERIOD_W-1:0] low_in, low_lat;
  logic [COUNT_W-1:0]  number_lat;
  logic                stop_seen;
  logic                hi_load, lo_load, hi_term, lo_term, last, trig_nx;
  logic [WIDTH_W-1:0]  hi_val;

  // Effective high/low lengths: zero width means one cycle, and at least one low cycle always.
  always_comb begin
    w_in   = (trigger_width == '0) ? WIDTH_W'(1) : trigger_width;
    low_in = (trigger_period > PERIOD_W'(w_in)) ? (trigger_period - PERIOD_W'(w_in))
                                                : PERIOD_W'(1);
  end

  always_comb begin
    last    = stop | stop_seen | ((number_lat != '0) && (pulse_count == number_lat));
    hi_load = ((state == ST_IDLE) && start && enable_trigger) ||
              ((state == ST_LOW) && enable_trigger && !stop && lo_term);
    hi_val  = (state == ST_IDLE) ? w_in : w_lat;
    lo_load = (state == ST_HIGH) && enable_trigger && hi_term && !last;
    trig_nx = hi_load || ((state == ST_HIGH) && enable_trigger && !hi_term);
  end

  trigger_phase_counter #(.W(WIDTH_W)) u_high_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (hi_load),
    .load_value (hi_val),
    .terminal   (hi_term)
  );

  trigger_phase_counter #(.W(PERIOD_W)) u_low_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (lo_load),
    .load_value (low_lat),
    .terminal   (lo_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
      trigger_out <= 1'b0;
      number_lat  <= '0;
      w_lat       <= WIDTH_W'(1);
      low_lat     <= PERIOD_W'(1);
      stop_seen   <= 1'b0;
    end else begin
      done        <= 1'b0;
      trigger_out <= trig_nx;
      case (state)
        ST_IDLE: begin
          if (start && enable_trigger) begin
            state       <= ST_HIGH;
            busy        <= 1'b1;
            pulse_count <= COUNT_W'(1);
            number_lat  <= trigger_number;
            w_lat       <= w_in;
            low_lat     <= low_in;
            stop_seen   <= stop;
          end
        end
        ST_HIGH: begin
          if (!enable_trigger || (hi_term && last)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            stop_seen <= 1'b0;
          end else begin
            if (stop) stop_seen <= 1'b1;
            if (hi_term) state <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (!enable_trigger || stop) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            stop_seen <= 1'b0;
          end else if (lo_term) begin
            state       <= ST_HIGH;
            pulse_count <= pulse_count + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRIG_GEN_OBUFDS_EN
  OBUFDS u_trig_obufds (
    .I  (trigger_out),
    .O  (trigger_out_p),
    .OB (trigger_out_n)
  );
`else
  // Registered from the same next-value as trigger_out so both pins toggle with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      trigger_out_p <= 1'b0;
      trigger_out_n <= 1'b1;
    end else begin
      trigger_out_p <= trig_nx;
      trigger_out_n <= ~trig_nx;
    end
  end
`endif

endmodule

// File: tb/tb_trigger_generator.sv
// Bench for trigger_generator: directed train scenarios plus randomized stimulus vs a timeline model.
module tb_trigger_generator;
  import trigger_generator_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, enable_trigger = 1'b1;
  logic [9:0]  trigger_width = '0;
  logic [23:0] trigger_period = '0;
  logic [15:0] trigger_number = '0;
  logic        busy, done, trigger_out, trigger_out_p, trigger_out_n;
  logic [15:0] pulse_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  trigger_generator #(.WIDTH_W(10), .PERIOD_W(24), .COUNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .enable_trigger (enable_trigger),
    .trigger_width  (trigger_width),
    .trigger_period (trigger_period),
    .trigger_number (trigger_number),
    .busy           (busy),
    .done           (done),
    .pulse_count    (pulse_count),
    .trigger_out    (trigger_out),
    .trigger_out_p  (trigger_out_p),
    .trigger_out_n  (trigger_out_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a train is a time index t since the first high cycle; the output is high
  // whenever t mod (w+L) < w.
  bit          m_act = 1'b0, m_done = 1'b0, m_trig = 1'b0, m_stopp = 1'b0;
  int          m_t = 0, m_w = 1, m_l = 1, pos;
  logic [15:0] m_pc = '0, m_n = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0; m_done = 1'b0; m_pc = '0; m_stopp = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_act) begin
        if (start && enable_trigger) begin
          m_act = 1'b1; m_t = 0; m_pc = 16'd1; m_n = trigger_number; m_stopp = stop;
          m_w = (trigger_width == 0) ? 1 : int'(trigger_width);
          m_l = (int'(trigger_period) > m_w) ? int'(trigger_period) - m_w : 1;
        end
      end else if (!enable_trigger) begin
        m_act = 1'b0; m_done = 1'b1;
      end else begin
        pos = m_t % (m_w + m_l);
        if (pos < m_w) begin
          m_stopp = m_stopp | stop;
          if (pos == m_w - 1 && (m_stopp || (m_n != 0 && m_pc == m_n))) begin
            m_act = 1'b0; m_done = 1'b1;
          end else begin
            m_t++;
          end
        end else if (stop) begin
          m_act = 1'b0; m_done = 1'b1;
        end else begin
          m_t++;
          if (m_t % (m_w + m_l) == 0) m_pc = m_pc + 16'd1;
        end
      end
    end
    m_trig = m_act && ((m_t % (m_w + m_l)) < m_w);
  end

  always @(negedge clk) begin
    if (chk_on)
      check("cycle", {11'd0, trigger_out, trigger_out_p, trigger_out_n, busy, done, pulse_count},
            {11'd0, m_trig, m_trig, ~m_trig, m_act, m_done, m_pc});
  end

  int   cyc, rises, highs, dones, gap_bad, last_rise, exp_gap, fall_cyc, done_cyc;
  logic prev_trig;

  task automatic clear_stats(input int gap);
    rises = 0; highs = 0; dones = 0; gap_bad = 0; last_rise = -1; cyc = 0;
    fall_cyc = -1; done_cyc = -1; exp_gap = gap; prev_trig = trigger_out;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (trigger_out && !prev_trig) begin
      rises++;
      if (last_rise >= 0 && cyc - last_rise != exp_gap) gap_bad++;
      last_rise = cyc;
    end
    if (!trigger_out && prev_trig) fall_cyc = cyc;
    if (trigger_out) highs++;
    if (done) begin dones++; done_cyc = cyc; end
    prev_trig = trigger_out;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic setup(input int w, input int p, input int n);
    trigger_width = 10'(w); trigger_period = 24'(p); trigger_number = 16'(n);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  bit stop_sent;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    check("reset_outs", {trigger_out, trigger_out_p, trigger_out_n, busy, done}, 5'b00100);
    check("reset_count", pulse_count, 0);

    // 1: three pulses, 4 high / 6 low
    setup(4, 10, 3); clear_stats(10);
    pulse_start();
    setup(1, 3, 7);
    run(30);
    check("t1_rises", rises, 3);
    check("t1_highs", highs, 12);
    check("t1_gap", gap_bad, 0);
    check("t1_dones", dones, 1);
    check("t1_done_at_fall", done_cyc, fall_cyc);
    check("t1_pulse_count", pulse_count, 3);
    check("t1_model_pc", m_pc, 3);

    // 2: zero width and period give 1 high / 1 low
    setup(0, 0, 2); clear_stats(2);
    pulse_start();
    run(8);
    check("t2_rises", rises, 2);
    check("t2_highs", highs, 2);
    check("t2_gap", gap_bad, 0);
    check("t2_dones", dones, 1);
    check("t2_pulse_count", pulse_count, 2);

    // 3: continuous, stop during the third low phase
    setup(2, 5, 0); clear_stats(5); stop_sent = 1'b0;
    pulse_start();
    for (int i = 0; i < 60 && !stop_sent; i++) begin
      tick();
      if (rises == 3 && !trigger_out) begin
        stop = 1'b1; tick(); stop = 1'b0; stop_sent = 1'b1;
        check("t3_done", {done, busy, trigger_out}, 3'b100);
        check("t3_pulse_count", pulse_count, 3);
      end
    end
    check("t3_stop_reached", stop_sent, 1);
    run(10);
    check("t3_rises", rises, 3);

    // 4: stop mid-high never truncates; start while busy ignored
    setup(8, 20, 0); clear_stats(20);
    pulse_start();
    run(2);
    stop = 1'b1; tick(); stop = 1'b0;
    setup(3, 4, 1); start = 1'b1; tick(); start = 1'b0;
    run(30);
    check("t4_highs", highs, 8);
    check("t4_rises", rises, 1);
    check("t4_dones", dones, 1);
    check("t4_pulse_count", pulse_count, 1);

    // 5: enable dropped mid-high aborts at once; start with enable low ignored
    setup(8, 20, 0); clear_stats(20);
    pulse_start();
    run(2);
    enable_trigger = 1'b0; tick();
    check("t5_abort", {trigger_out, done, busy}, 3'b010);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_start_disabled", {trigger_out, busy}, 2'b00);
    enable_trigger = 1'b1;
    run(3);

    // 6: reset mid-train
    setup(6, 12, 0); clear_stats(12);
    pulse_start();
    run(3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_reset", {trigger_out, trigger_out_p, trigger_out_n, busy, done}, 5'b00100);
    check("t6_reset_count", pulse_count, 0);
    run(3);
    check("t6_no_done", dones, 0);

    // randomized stimulus, including config churn while busy
    for (int i = 0; i < 4000; i++) begin
      start          = ($urandom_range(0, 7) == 0);
      stop           = ($urandom_range(0, 24) == 0);
      enable_trigger = ($urandom_range(0, 79) != 0);
      rst            = ($urandom_range(0, 499) == 0);
      trigger_width  = 10'($urandom_range(0, 6));
      trigger_period = 24'($urandom_range(0, 14));
      trigger_number = 16'($urandom_range(0, 4));
      tick();
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0; enable_trigger = 1'b1;
    run(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
